// File: rtl/dram_bank_cmd_engine_if.sv
// Command/data bus of the DRAM bank command engine.
// The master side is the DDR command decoder; the slave side is the engine.
interface dram_bank_cmd_engine_if #(
    parameter int unsigned BGWIDTH      = 2,
    parameter int unsigned BAWIDTH      = 2,
    parameter int unsigned ADDRWIDTH    = 4,
    parameter int unsigned COLWIDTH     = 3,
    parameter int unsigned DEVICE_WIDTH = 4
);
    localparam int unsigned BANKS = 2 ** (BGWIDTH + BAWIDTH);

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [2:0]              cmd;
    logic [BGWIDTH-1:0]      bg;
    logic [BAWIDTH-1:0]      ba;
    logic [ADDRWIDTH-1:0]    row;
    logic [COLWIDTH-1:0]     column;
    logic [DEVICE_WIDTH-1:0] dqin;
    logic [DEVICE_WIDTH-1:0] dqout;
    logic                    rd_valid;
    logic                    wr_req;
    logic                    err;
    logic [BANKS-1:0]        bank_open;

    modport master (
        output cmd_valid, cmd, bg, ba, row, column, dqin,
        input  cmd_ready, dqout, rd_valid, wr_req, err, bank_open
    );

    modport slave (
        input  cmd_valid, cmd, bg, ba, row, column, dqin,
        output cmd_ready, dqout, rd_valid, wr_req, err, bank_open
    );
endinterface

// File: rtl/dram_bank_cmd_engine.sv
// Per-bank DRAM command engine: ACT/PRE timing per bank, one RD/WR burst at a time,
// behavioural storage array that survives reset.
module dram_bank_cmd_engine #(
    parameter int unsigned BGWIDTH      = 2,
    parameter int unsigned BAWIDTH      = 2,
    parameter int unsigned ADDRWIDTH    = 4,
    parameter int unsigned COLWIDTH     = 3,
    parameter int unsigned DEVICE_WIDTH = 4,
    parameter int unsigned BL           = 8,
    parameter int unsigned TRCD         = 3,
    parameter int unsigned TRP          = 3,
    parameter int unsigned CL           = 4,
    parameter int unsigned CWL          = 3
) (
    input logic                   clk,
    input logic                   reset,
    dram_bank_cmd_engine_if.slave io_bus
);
    localparam int unsigned BW     = BGWIDTH + BAWIDTH;
    localparam int unsigned BANKS  = 2 ** BW;
    localparam int unsigned AW     = BW + ADDRWIDTH + COLWIDTH;
    localparam int unsigned DEPTH  = 2 ** AW;
    localparam int unsigned LATMAX = (CL > CWL) ? CL : CWL;
    localparam int unsigned CNTW   = $clog2(LATMAX + BL + 1);
    localparam int unsigned TMAX   = (TRCD > TRP) ? TRCD : TRP;
    localparam int unsigned TW     = $clog2(TMAX + 1);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    localparam logic [1:0] StIdle        = 2'd0;
    localparam logic [1:0] StActivating  = 2'd1;
    localparam logic [1:0] StActive      = 2'd2;
    localparam logic [1:0] StPrecharging = 2'd3;

    logic [1:0]              r_state    [BANKS];
    logic [TW-1:0]           r_tcnt     [BANKS];
    logic [ADDRWIDTH-1:0]    r_open_row [BANKS];
    logic [DEVICE_WIDTH-1:0] r_mem      [DEPTH];

    logic                r_busy;
    logic                r_is_rd;
    logic                r_err;
    logic [CNTW-1:0]     r_cyc;
    logic [BW-1:0]       r_bank;
    logic [COLWIDTH-1:0] r_col;

    logic                w_accept;
    logic [BW-1:0]       w_bank;
    logic [1:0]          w_st;
    logic                w_act_go;
    logic                w_pre_go;
    logic                w_rd_go;
    logic                w_wr_go;
    logic                w_illegal;
    logic [CNTW-1:0]     w_lat;
    logic                w_beat;
    logic [COLWIDTH-1:0] w_k;
    logic [COLWIDTH-1:0] w_col;
    logic [AW-1:0]       w_addr;
    logic [BANKS-1:0]    w_open;

    assign w_accept = io_bus.cmd_valid & ~r_busy;
    assign w_bank   = {io_bus.bg, io_bus.ba};
    assign w_st     = r_state[w_bank];

    always_comb begin
        w_act_go  = 1'b0;
        w_pre_go  = 1'b0;
        w_rd_go   = 1'b0;
        w_wr_go   = 1'b0;
        w_illegal = 1'b0;
        if (w_accept) begin
            case (io_bus.cmd)
                CMD_NOP: ;
                CMD_ACT: if (w_st == StIdle) w_act_go = 1'b1; else w_illegal = 1'b1;
                CMD_RD:  if (w_st == StActive) w_rd_go = 1'b1; else w_illegal = 1'b1;
                CMD_WR:  if (w_st == StActive) w_wr_go = 1'b1; else w_illegal = 1'b1;
                // PRE to an idle bank is a silent no-op
                CMD_PRE: if (w_st == StActive) w_pre_go = 1'b1;
                         else if (w_st != StIdle) w_illegal = 1'b1;
                default: w_illegal = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < BANKS; b++) begin
                r_state[b]    <= StIdle;
                r_tcnt[b]     <= '0;
                r_open_row[b] <= '0;
            end
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                case (r_state[b])
                    StActivating:  if (r_tcnt[b] <= TW'(1)) r_state[b] <= StActive;
                                   else r_tcnt[b] <= r_tcnt[b] - 1'b1;
                    StPrecharging: if (r_tcnt[b] <= TW'(1)) r_state[b] <= StIdle;
                                   else r_tcnt[b] <= r_tcnt[b] - 1'b1;
                    default: ;
                endcase
                if (w_act_go && (w_bank == BW'(b))) begin
                    r_state[b]    <= (TRCD > 1) ? StActivating : StActive;
                    r_tcnt[b]     <= TW'(TRCD - 1);
                    r_open_row[b] <= io_bus.row;
                end
                if (w_pre_go && (w_bank == BW'(b))) begin
                    r_state[b] <= (TRP > 1) ? StPrecharging : StIdle;
                    r_tcnt[b]  <= TW'(TRP - 1);
                end
            end
        end
    end

    // r_cyc counts cycles since acceptance; beats occupy [lat, lat+BL-1]
    assign w_lat  = r_is_rd ? CNTW'(CL) : CNTW'(CWL);
    assign w_beat = r_busy && (r_cyc >= w_lat);
    assign w_k    = COLWIDTH'(r_cyc - w_lat);
    assign w_col  = (r_col & ~COLWIDTH'(BL - 1)) | ((r_col + w_k) & COLWIDTH'(BL - 1));
    assign w_addr = {r_bank, r_open_row[r_bank], w_col};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_is_rd <= 1'b0;
            r_cyc   <= '0;
            r_bank  <= '0;
            r_col   <= '0;
        end else if (w_rd_go || w_wr_go) begin
            r_busy  <= 1'b1;
            r_is_rd <= w_rd_go;
            r_cyc   <= CNTW'(1);
            r_bank  <= w_bank;
            r_col   <= io_bus.column;
        end else if (r_busy) begin
            r_cyc <= r_cyc + 1'b1;
            if (r_cyc == w_lat + CNTW'(BL - 1)) r_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_err <= 1'b0;
        else       r_err <= w_illegal;
    end

    // Storage has no reset; a beat landing in a reset cycle is discarded
    always_ff @(posedge clk) begin
        if (!reset && w_beat && !r_is_rd) r_mem[w_addr] <= io_bus.dqin;
    end

    always_comb begin
        w_open = '0;
        for (int b = 0; b < BANKS; b++) w_open[b] = (r_state[b] == StActive);
    end

    assign io_bus.cmd_ready = ~r_busy;
    assign io_bus.rd_valid  = w_beat & r_is_rd;
    assign io_bus.wr_req    = w_beat & ~r_is_rd;
    assign io_bus.dqout     = (w_beat && r_is_rd) ? r_mem[w_addr] : '0;
    assign io_bus.err       = r_err;
    assign io_bus.bank_open = w_open;
endmodule
